muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS datapath. It is the parametrised successor to the combinational ALU multiply path. It adds signed and unsigned multiply, signed and unsigned divide, and direct HI/LO writes, and it works at any even-or-odd operand width. It sits beside the ALU in the execute stage. The control unit starts an operation with a start/busy/done handshake and reads HI/LO directly.

## Interface
- WIDTH, 32, operand and HI/LO width; legal range 2..64.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only while busy=0.
- op  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (ignored).
- a  in  WIDTH  operand A: multiplicand, dividend, or MTHI/MTLO data. Sampled with start.
- b  in  WIDTH  operand B: multiplier or divisor. Sampled with start.
- busy  out  1  high while a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse when HI/LO take a multiply/divide result.
- div_zero  out  1  valid with done; high if the divisor was 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- Reset (reset_n=0 at a rising edge):
  - state goes to IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0.
  - This applies mid-operation: the operation is aborted and no done pulse is produced.
- States: IDLE, RUN, FINISH.
- IDLE, start=1, op=4 (MTHI): hi<=a in one cycle. No busy, no done.
- IDLE, start=1, op=5 (MTLO): lo<=a in one cycle. No busy, no done.
- IDLE, start=1, op 0-3:
  - Latch operand magnitudes. Signed ops take the absolute value of any negative operand; unsigned ops use operands as-is.
  - Latch the result sign flags: quotient/product sign = a[W-1]^b[W-1]; remainder sign = a[W-1].
  - Latch div_zero_pending = (b==0) for divide ops.
  - Clear the iteration counter and go to RUN.
- IDLE, op 6-7: no effect.
- RUN, multiply: radix-2 shift-add on a 2*WIDTH accumulator, one bit of the multiplier per cycle, exactly WIDTH cycles.
- RUN, divide: restoring division, one quotient bit per cycle, exactly WIDTH cycles.
- RUN exits to FINISH when the counter reaches WIDTH-1.
- FINISH (one cycle):
  - Apply sign correction as two's-complement negation. Signed multiply negates the full 2*WIDTH product if the sign flag is set. Signed divide negates the quotient and remainder by their own flags.
  - Write hi/lo: multiply gives hi=product[2W-1:W], lo=product[W-1:0]; divide gives lo=quotient, hi=remainder.
  - done=1, div_zero=div_zero_pending; return to IDLE.
- Divide by zero (DIV or DIVU): lo=all ones, hi=a (original, uncorrected dividend), div_zero=1. Latency is unchanged.
- Signed DIV of most-negative / -1: lo=most-negative (wraps), hi=0, div_zero=0.
- start while busy=1 is ignored, and operands are not re-sampled. There is no queueing.
- All arithmetic is modulo 2^WIDTH per register; no overflow flag.

## Timing
- Edge E0 samples start (op 0-3). busy=1 from after E0.
- Edges E1..E_WIDTH perform the iterations. State is FINISH after E_WIDTH.
- Edge E_WIDTH+1 writes hi/lo and returns to IDLE. After it, done=1 and div_zero is valid for exactly one cycle, and busy=0.
- Total latency is WIDTH+1 cycles from the start edge to the result edge, independent of operand values.
- busy is high for WIDTH+1 cycles. The earliest next start is accepted at E_WIDTH+2.
- start held high through done launches a new operation at E_WIDTH+2 with the inputs present then.
- MTHI/MTLO take effect at the start edge and are visible the next cycle.
- done and div_zero are 0 in every cycle other than the pulse cycle.

## Test plan
- Reset: assert reset_n=0 for 2 cycles with start=1 -> hi=0, lo=0, busy=0, done=0.
- WIDTH=32, MULT with a=0xFFFFFFFD (-3), b=5:
  - done exactly 33 cycles after start -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - Same operands as MULTU -> hi=0x00000004, lo=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_zero=1 with done.
- Start during busy: pulse start with MULTU 2*3 at cycle 5 of a DIV -> it is ignored and the DIV result is unaffected.
- Reset mid-operation: drop reset_n at cycle 10 of a DIV -> no done pulse, hi=lo=0; a new MTLO 0xA5A5A5A5 afterwards gives lo=0xA5A5A5A5 next cycle.
- WIDTH=8 regression: MULT 0x80*0x80 -> hi=0x40, lo=0x00 after 9 cycles.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Start/busy/done handshake and HI/LO read-back between the control unit and muldiv_unit.
// The control unit drives start/op/a/b; the unit returns status and the HI/LO registers.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide owning HI/LO: WIDTH+1 cycles start-to-result, MTHI/MTLO in one cycle.
// No queueing: start is ignored while busy, so the issuer must wait for busy to drop.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   orig_a;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               dz_pend;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  always_comb begin
    a_neg    = ~bus.op[0] & bus.a[WIDTH-1];
    b_neg    = ~bus.op[0] & bus.b[WIDTH-1];
    a_mag    = a_neg ? -bus.a : bus.a;
    b_mag    = b_neg ? -bus.b : bus.b;
    // Multiply: acc = {partial product, remaining multiplier bits}.
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Divide: acc = {remainder, remaining dividend / quotient bits}; trial[WIDTH] is the borrow.
    trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      acc          <= '0;
      opnd         <= '0;
      orig_a       <= '0;
      cnt          <= '0;
      is_div       <= 1'b0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      dz_pend      <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'd4: bus.hi <= bus.a;
              3'd5: bus.lo <= bus.a;
              3'd0, 3'd1, 3'd2, 3'd3: begin
                opnd     <= bus.op[1] ? b_mag : a_mag;
                acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? a_mag : b_mag)};
                orig_a   <= bus.a;
                is_div   <= bus.op[1];
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                dz_pend  <= bus.op[1] & (bus.b == '0);
                cnt      <= '0;
                bus.busy <= 1'b1;
                state    <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (is_div) begin
            acc <= trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
          end else begin
            acc <= {add_sum, acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= FINISH;
        end
        FINISH: begin
          if (is_div && dz_pend) begin
            bus.hi <= orig_a;
            bus.lo <= '1;
          end else if (is_div) begin
            bus.hi <= r_fix;
            bus.lo <= q_fix;
          end else begin
            bus.hi <= prod_fix[2*WIDTH-1:WIDTH];
            bus.lo <= prod_fix[WIDTH-1:0];
          end
          bus.done     <= 1'b1;
          bus.div_zero <= dz_pend;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks of muldiv_unit at WIDTH=32 (vector table plus handshake corner cases) and WIDTH=8.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt = 0;
  int   total = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) m32 ();
  muldiv_unit_if #(.WIDTH(8))  m8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset_n(reset_n), .bus(m32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset_n(reset_n), .bus(m8));

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issues one op on the 32-bit unit and waits for done; inject=1 pulses a MULTU at cycle 5.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit inject, output int cyc);
    @(negedge clk);
    m32.start = 1'b1; m32.op = op; m32.a = a; m32.b = b;
    @(negedge clk);
    m32.start = 1'b0;
    check("busy_after_start", 64'(m32.busy), 64'd1);
    cyc = 0;
    while (!m32.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (inject && cyc == 5) begin
        m32.start = 1'b1; m32.op = 3'd1; m32.a = 32'd2; m32.b = 32'd3;
      end else begin
        m32.start = 1'b0;
      end
    end
  endtask

  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int cyc);
    @(negedge clk);
    m8.start = 1'b1; m8.op = op; m8.a = a; m8.b = b;
    @(negedge clk);
    m8.start = 1'b0;
    cyc = 0;
    while (!m8.done && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    bit  seen;

    vecs[0] = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[1] = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 1'b0};
    vecs[2] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[3] = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5] = '{3'd3, 32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[6] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[7] = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8] = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    vecs[9] = '{3'd0, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF2, 1'b0};

    // Reset held two cycles with start asserted.
    reset_n = 1'b0;
    m32.start = 1'b1; m32.op = 3'd5; m32.a = 32'hDEADBEEF; m32.b = 32'd0;
    m8.start = 1'b0; m8.op = 3'd0; m8.a = 8'd0; m8.b = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hi", 64'(m32.hi), 64'd0);
    check("reset_lo", 64'(m32.lo), 64'd0);
    check("reset_busy", 64'(m32.busy), 64'd0);
    check("reset_done", 64'(m32.done), 64'd0);
    m32.start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run32(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, cyc);
      check($sformatf("v%0d_latency", i), 64'(cyc), 64'd33);
      check($sformatf("v%0d_hi", i), 64'(m32.hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(m32.lo), 64'(vecs[i].lo));
      check($sformatf("v%0d_div_zero", i), 64'(m32.div_zero), 64'(vecs[i].dz));
      check($sformatf("v%0d_busy_at_done", i), 64'(m32.busy), 64'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 64'({m32.done, m32.div_zero}), 64'd0);
    end

    // MTHI / MTLO take effect in one cycle; reserved op leaves HI/LO untouched.
    @(negedge clk);
    m32.start = 1'b1; m32.op = 3'd4; m32.a = 32'h0BADF00D;
    @(posedge clk); #1;
    check("mthi_hi", 64'(m32.hi), 64'h0BADF00D);
    check("mthi_busy", 64'({m32.busy, m32.done}), 64'd0);
    @(negedge clk);
    m32.op = 3'd5; m32.a = 32'h13579BDF;
    @(posedge clk); #1;
    check("mtlo_lo", 64'(m32.lo), 64'h13579BDF);
    @(negedge clk);
    m32.op = 3'd6; m32.a = 32'hFFFF0000;
    @(posedge clk); #1;
    check("reserved_hilo", {m32.hi, m32.lo}, {32'h0BADF00D, 32'h13579BDF});
    check("reserved_busy", 64'(m32.busy), 64'd0);
    m32.start = 1'b0;

    // A start pulsed mid-divide must be ignored.
    run32(3'd2, 32'd100, 32'd7, 1'b1, cyc);
    check("busy_start_latency", 64'(cyc), 64'd33);
    check("busy_start_result", {m32.hi, m32.lo}, {32'd2, 32'd14});
    @(posedge clk); #1;
    check("busy_start_no_new_op", 64'(m32.busy), 64'd0);

    // Reset mid-divide aborts without a done pulse.
    @(negedge clk);
    m32.start = 1'b1; m32.op = 3'd2; m32.a = 32'd1000; m32.b = 32'd3;
    @(negedge clk);
    m32.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk); #1;
    check("midop_reset_hilo", {m32.hi, m32.lo}, 64'd0);
    check("midop_reset_busy", 64'(m32.busy), 64'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (m32.done) seen = 1'b1;
    end
    check("midop_reset_no_done", 64'(seen), 64'd0);
    @(negedge clk);
    m32.start = 1'b1; m32.op = 3'd5; m32.a = 32'hA5A5A5A5;
    @(posedge clk); #1;
    check("post_reset_mtlo", 64'(m32.lo), 64'hA5A5A5A5);
    m32.start = 1'b0;

    // WIDTH=8 instance.
    run8(3'd0, 8'h80, 8'h80, cyc);
    check("w8_mult_latency", 64'(cyc), 64'd9);
    check("w8_mult_hilo", 64'({m8.hi, m8.lo}), 64'h4000);
    run8(3'd1, 8'hFF, 8'hFF, cyc);
    check("w8_multu_hilo", 64'({m8.hi, m8.lo}), 64'hFE01);
    run8(3'd2, 8'h80, 8'hFF, cyc);
    check("w8_div_ovf", 64'({m8.hi, m8.lo}), 64'h0080);
    check("w8_div_ovf_dz", 64'(m8.div_zero), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
